// File: rtl/tag_pri_sched_pkg.sv
// Shared types and constants for the per-priority tag buffer and strict-priority scheduler.
package tag_pri_sched_pkg;
  localparam int ADDR_LEN      = 8;
  localparam int PRI_NUM       = 8;
  localparam int PRI_W         = 3;
  localparam int SRCPORT_W     = 4;
  localparam int MSG_W         = ADDR_LEN + 4;
  localparam int PLD_W         = ADDR_LEN + 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic [MSG_W-1:0]     msg;
    logic [SRCPORT_W-1:0] src_port;
  } tag_t;

  typedef struct packed {
    logic [PRI_W-1:0] pri;
    tag_t             tag;
  } sched_tag_t;

  // Index of the highest set bit; priority 7 wins.
  function automatic logic [PRI_W-1:0] highest_set(input logic [PRI_NUM-1:0] v);
    logic [PRI_W-1:0] r;
    r = '0;
    for (int i = 0; i < PRI_NUM; i++) begin
      if (v[i]) r = PRI_W'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/tag_pri_sched_fifo.sv
// Synchronous FIFO with extra-MSB pointers; combinational read of the head entry.
module tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/tag_pri_sched.sv
// Eight per-priority tag FIFOs feeding a strict-priority scheduler with a single output register.
module tag_pri_sched
  import tag_pri_sched_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRI_NUM-1:0] tag_in_vld,
  input  tag_t               tag_in_pld [PRI_NUM],
  output logic [PRI_NUM-1:0] tag_in_rdy,
  output logic               tag_out_vld,
  input  logic               tag_out_rdy,
  output sched_tag_t         tag_out_pld,
  output logic [PRI_NUM-1:0] queue_empty,
  output logic [PRI_NUM-1:0] queue_full
);
  tag_t               fifo_dout [PRI_NUM];
  logic [PRI_NUM-1:0] non_empty;
  logic [PRI_NUM-1:0] pop_oh;
  logic [PRI_W-1:0]   sel;
  logic               load_en;

  for (genvar g = 0; g < PRI_NUM; g++) begin : g_fifo
    tag_fifo #(
      .DEPTH (DEPTH),
      .W     (PLD_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tag_in_vld[g]),
      .pop   (pop_oh[g]),
      .din   (tag_in_pld[g]),
      .dout  (fifo_dout[g]),
      .empty (queue_empty[g]),
      .full  (queue_full[g])
    );
  end

  // Ready depends only on occupancy, so a full queue stays not-ready even while it is popped.
  assign tag_in_rdy = ~queue_full;
  assign non_empty  = ~queue_empty;
  assign load_en    = (!tag_out_vld || tag_out_rdy) && (|non_empty);
  assign sel        = highest_set(non_empty);

  always_comb begin
    // NOTE: default first so every path assigns pop_oh and no latch is inferred.
    pop_oh = '0;
    if (load_en) pop_oh[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_out_vld <= 1'b0;
      tag_out_pld <= '0;
    end else if (load_en) begin
      tag_out_vld <= 1'b1;
      tag_out_pld <= {sel, fifo_dout[sel]};
    end else if (tag_out_rdy) begin
      tag_out_vld <= 1'b0;
    end
  end
endmodule
